// File: rtl/systolic_output_collector.sv
// Output-edge collector for the systolic array: removes the per-column diagonal
// skew and queues one aligned COL-wide vector per array row in a FWFT FIFO.
module systolic_output_collector #(
    parameter int WIDTH = 8,
    parameter int COL   = 2,
    parameter int DEPTH = 4
) (
    input  logic                       clk_in,
    input  logic                       nrst_in,
    input  logic                       clear_in,
    input  logic                       col_valid_in,
    input  logic [WIDTH*COL-1:0]       col_data_in,
    output logic [WIDTH*COL-1:0]       out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic                       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int VW = WIDTH * COL;

    logic [VW-1:0] aligned;
    logic          aligned_valid;
    logic          pipe_busy;

    // Column j arrives j cycles late, so it is held COL-1-j cycles to line up
    // with the last column, which is used straight off the input.
    for (genvar j = 0; j < COL; j++) begin : g_col
        localparam int LEN = COL - 1 - j;
        if (LEN == 0) begin : g_pass
            assign aligned[j*WIDTH +: WIDTH] = col_data_in[j*WIDTH +: WIDTH];
        end else begin : g_dly
            logic [WIDTH-1:0] dly_q [LEN];
            logic [WIDTH-1:0] dly_d [LEN];

            always_comb begin
                dly_d[0] = col_data_in[j*WIDTH +: WIDTH];
                for (int k = 1; k < LEN; k++) begin
                    dly_d[k] = dly_q[k-1];
                end
            end

            always_ff @(posedge clk_in or negedge nrst_in) begin
                if (!nrst_in) begin
                    for (int k = 0; k < LEN; k++) begin
                        dly_q[k] <= '0;
                    end
                end else begin
                    dly_q <= dly_d;
                end
            end

            assign aligned[j*WIDTH +: WIDTH] = dly_q[LEN-1];
        end
    end

    if (COL > 1) begin : g_vpipe
        logic [COL-2:0] vld_q;
        logic [COL-2:0] vld_d;

        always_comb begin
            vld_d[0] = col_valid_in;
            for (int k = 1; k < COL - 1; k++) begin
                vld_d[k] = vld_q[k-1];
            end
            if (clear_in) begin
                vld_d = '0;
            end
        end

        always_ff @(posedge clk_in or negedge nrst_in) begin
            if (!nrst_in) begin
                vld_q <= '0;
            end else begin
                vld_q <= vld_d;
            end
        end

        assign aligned_valid = vld_q[COL-2];
        assign pipe_busy     = |vld_q;
    end else begin : g_novpipe
        assign aligned_valid = col_valid_in;
        assign pipe_busy     = 1'b0;
    end

    logic [VW-1:0] mem_q [DEPTH];
    logic [VW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          pop;
    logic          push;
    logic          full;

    // A pop frees the head slot in the same cycle, so a full FIFO still
    // accepts a push when the consumer is draining.
    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        pop      = (count_q != '0) && out_ready;
        push     = aligned_valid && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (clear_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = aligned;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
            if (aligned_valid && !push) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign busy       = col_valid_in | pipe_busy | (count_q != '0);

endmodule

// File: tb/tb_systolic_output_collector.sv
// Bench for systolic_output_collector: directed and random rows checked every
// cycle against a row-level queue model of the collector.
module tb_systolic_output_collector;

    localparam int WIDTH = 8;
    localparam int COL   = 2;
    localparam int DEPTH = 4;
    localparam int DW    = WIDTH * COL;

    logic                   clk_in = 1'b0;
    logic                   nrst_in;
    logic                   clear_in;
    logic                   col_valid_in;
    logic [DW-1:0]          col_data_in;
    logic [DW-1:0]          out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;
    logic                   busy;

    systolic_output_collector #(.WIDTH(WIDTH), .COL(COL), .DEPTH(DEPTH)) dut (
        .clk_in       (clk_in),
        .nrst_in      (nrst_in),
        .clear_in     (clear_in),
        .col_valid_in (col_valid_in),
        .col_data_in  (col_data_in),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 clk_in = ~clk_in;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc   = 0;
    logic [DW-1:0] q [$];
    int            pend_t [$];
    logic [DW-1:0] pend_d [$];
    bit            m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'(q.size() != 0));
        chk({tag, "_data"},  32'(out_data),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
        chk({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
        chk({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
        chk({tag, "_busy"},  32'(busy),      32'((pend_t.size() != 0) || (q.size() != 0)));
    endtask

    // One clock cycle: drive, check, then advance the model past the edge.
    task automatic step(input bit v, input bit rdy, input bit clr, input logic [DW-1:0] row);
        logic [DW-1:0] bus;
        bit            pop;
        col_valid_in = v;
        out_ready    = rdy;
        clear_in     = clr;
        if (v) begin
            pend_t.push_back(cyc);
            pend_d.push_back(row);
        end
        for (int j = 0; j < COL; j++) begin
            bus[j*WIDTH +: WIDTH] = WIDTH'($urandom);
            for (int i = 0; i < pend_t.size(); i++) begin
                if (pend_t[i] == cyc - j) bus[j*WIDTH +: WIDTH] = pend_d[i][j*WIDTH +: WIDTH];
            end
        end
        col_data_in = bus;
        #2;
        check_outputs("cyc");
        @(posedge clk_in);
        #1;
        pop = (q.size() != 0) && rdy;
        if (clr) begin
            q.delete();
            pend_t.delete();
            pend_d.delete();
            m_ovf = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (pend_t.size() != 0 && pend_t[0] + COL - 1 == cyc) begin
                if (q.size() < DEPTH) q.push_back(pend_d[0]);
                else m_ovf = 1'b1;
                void'(pend_t.pop_front());
                void'(pend_d.pop_front());
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, rdy, 1'b0, DW'($urandom));
    endtask

    initial begin
        nrst_in      = 1'b0;
        clear_in     = 1'b0;
        col_valid_in = 1'b0;
        col_data_in  = '0;
        out_ready    = 1'b0;
        repeat (2) @(posedge clk_in);
        #3;
        check_outputs("rst");
        nrst_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Single row, latency COL
        step(1'b1, 1'b1, 1'b0, 16'h2211);
        step(1'b0, 1'b1, 1'b0, DW'($urandom));
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'h2211);
        idle(3, 1'b1);

        // Back-to-back rows with a draining consumer
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0, {8'(8'hA0 + i), 8'(i)});
        idle(4, 1'b1);

        // Overfill with consumer stalled
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 1'b0, {8'(8'hA0 + i), 8'(i)});
        idle(1, 1'b0);
        chk("t3_count", 32'(fifo_count), 32'd4);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_head", 32'(out_data), 32'hA101);
        idle(6, 1'b1);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);

        // Push into a full FIFO while popping
        step(1'b0, 1'b0, 1'b1, '0);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b0, {8'(8'hB0 + i), 8'(8'h10 + i)});
        step(1'b1, 1'b0, 1'b0, 16'hB515);
        step(1'b0, 1'b1, 1'b0, DW'($urandom));
        chk("t4_count", 32'(fifo_count), 32'd4);
        chk("t4_ovf", 32'(overflow), 32'd0);
        idle(6, 1'b1);

        // Clear while a row is mid-skew
        step(1'b1, 1'b0, 1'b0, 16'hC121);
        step(1'b1, 1'b0, 1'b0, 16'hC222);
        step(1'b1, 1'b0, 1'b0, 16'hC323);
        step(1'b0, 1'b0, 1'b1, DW'($urandom));
        chk("t5_count", 32'(fifo_count), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        step(1'b1, 1'b1, 1'b0, 16'hC424);
        step(1'b0, 1'b1, 1'b0, DW'($urandom));
        chk("t5_fresh", 32'(out_data), 32'hC424);
        idle(3, 1'b1);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 29) == 0), DW'($urandom));
        end
        idle(8, 1'b1);

        // Asynchronous reset with three vectors held
        step(1'b0, 1'b0, 1'b1, '0);
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b0, DW'($urandom));
        step(1'b0, 1'b0, 1'b0, DW'($urandom));
        chk("t6_pre_count", 32'(fifo_count), 32'd3);
        #2;
        nrst_in = 1'b0;
        #1;
        q.delete();
        pend_t.delete();
        pend_d.delete();
        m_ovf = 1'b0;
        check_outputs("t6_rst");
        @(posedge clk_in);
        #1;
        nrst_in = 1'b1;
        @(posedge clk_in);
        #1;
        step(1'b1, 1'b1, 1'b0, 16'h2211);
        step(1'b0, 1'b1, 1'b0, DW'($urandom));
        chk("t6_data", 32'(out_data), 32'h2211);
        idle(3, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
